// File: rtl/cu_pkg.sv
// Shared definitions for the multicycle control unit: FSM states, opcodes,
// instruction classes and write-back source codes.
package cu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH,
    CL_JAL, CL_JALR, CL_LUI, CL_AUIPC, CL_ILL
  } iclass_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] WB_DM  = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  localparam logic [31:0] IR_NOP = 32'h0000_0013;

  function automatic logic [1:0] wb_sel_of(input iclass_e c);
    case (c)
      CL_LOAD:          return WB_DM;
      CL_JAL, CL_JALR:  return WB_PC4;
      CL_LUI:           return WB_IMM;
      default:          return WB_ALU;
    endcase
  endfunction

endpackage

// File: rtl/cu_decoder.sv
// Opcode classifier; every legal opcode ends in 2'b11, so a full 7-bit match
// also rejects compressed encodings.
module cu_decoder
  import cu_pkg::*;
#(
  parameter int ENABLE_U = 1
) (
  input  logic [6:0] opcode,
  output iclass_e    iclass,
  output logic       illegal
);

  always_comb begin
    iclass = CL_ILL;
    case (opcode)
      OP_R:      iclass = CL_R;
      OP_I:      iclass = CL_I;
      OP_LOAD:   iclass = CL_LOAD;
      OP_STORE:  iclass = CL_STORE;
      OP_BRANCH: iclass = CL_BRANCH;
      OP_JAL:    iclass = CL_JAL;
      OP_JALR:   iclass = CL_JALR;
      OP_LUI:    iclass = (ENABLE_U != 0) ? CL_LUI : CL_ILL;
      OP_AUIPC:  iclass = (ENABLE_U != 0) ? CL_AUIPC : CL_ILL;
      default:   iclass = CL_ILL;
    endcase
    illegal = (iclass == CL_ILL);
  end

endmodule

// File: rtl/multicycle_cu.sv
// Multicycle RV32 control unit: FETCH/DECODE/EXEC/MEM/WB FSM with a memory
// handshake timeout that traps; outputs are quiet while reset is held.
module multicycle_cu
  import cu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENABLE_U = 1,
  parameter int TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        mem_ack,
  input  logic        branch_taken,
  output logic        im_req,
  output logic        dm_req,
  output logic        dm_we,
  output logic [2:0]  dm_ctrl,
  output logic        pc_we,
  output logic        pc_sel,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        rf_we,
  output logic [2:0]  alu_func3,
  output logic        alu_subsra,
  output logic        op1_sel,
  output logic        op2_sel,
  output logic [1:0]  wb_sel,
  output logic [2:0]  br_op,
  output logic        illegal,
  output logic [2:0]  state
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [7:0]  cnt_q, cnt_d;
  iclass_e     iclass;
  logic        dec_illegal;
  logic        mem_phase;
  logic        timed_out;
  logic [2:0]  func3;

  cu_decoder #(.ENABLE_U(ENABLE_U)) u_dec (
    .opcode  (ir_q[6:0]),
    .iclass  (iclass),
    .illegal (dec_illegal)
  );

  assign func3      = ir_q[14:12];
  assign rs1        = ir_q[19:15];
  assign rs2        = ir_q[24:20];
  assign rd         = ir_q[11:7];
  assign dm_ctrl    = func3;
  assign br_op      = func3;
  // Address, jump and upper-immediate arithmetic is always an add.
  assign alu_func3  = (iclass == CL_R || iclass == CL_I) ? func3 : 3'b000;
  assign alu_subsra = (iclass == CL_R || (iclass == CL_I && func3 == 3'b101)) ? ir_q[30] : 1'b0;
  assign state      = state_q;

  assign mem_phase  = (state_q == ST_FETCH) || (state_q == ST_MEM);
  // An ack in the final allowed cycle still wins over the timeout.
  assign timed_out  = mem_phase && !mem_ack && (cnt_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      ir_q    <= IR_NOP;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ack) begin
          state_d = ST_DECODE;
          ir_d    = instr;
        end else if (timed_out) begin
          state_d = ST_TRAP;
        end
      end
      ST_DECODE: state_d = dec_illegal ? ST_TRAP : ST_EXEC;
      ST_EXEC: begin
        case (iclass)
          CL_BRANCH:         state_d = ST_FETCH;
          CL_LOAD, CL_STORE: state_d = ST_MEM;
          default:           state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (mem_ack)        state_d = (iclass == CL_STORE) ? ST_FETCH : ST_WB;
        else if (timed_out) state_d = ST_TRAP;
      end
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_TRAP;
    endcase

    if (state_d != state_q)      cnt_d = 8'd0;
    else if (mem_phase && !mem_ack) cnt_d = cnt_q + 8'd1;
    else                         cnt_d = cnt_q;
  end

  always_comb begin
    im_req  = 1'b0;
    dm_req  = 1'b0;
    dm_we   = 1'b0;
    pc_we   = 1'b0;
    pc_sel  = 1'b0;
    rf_we   = 1'b0;
    op1_sel = 1'b1;
    op2_sel = 1'b0;
    wb_sel  = WB_ALU;
    illegal = 1'b0;
    if (!reset) begin
      // Operand and write-back selects stay stable from EXEC through WB.
      if (state_q inside {ST_EXEC, ST_MEM, ST_WB}) begin
        op1_sel = !(iclass inside {CL_BRANCH, CL_JAL, CL_AUIPC});
        op2_sel = (iclass != CL_R);
        wb_sel  = wb_sel_of(iclass);
      end
      case (state_q)
        ST_FETCH: im_req = 1'b1;
        ST_EXEC: begin
          if (iclass == CL_BRANCH) begin
            pc_we  = 1'b1;
            pc_sel = branch_taken;
          end
        end
        ST_MEM: begin
          dm_req = 1'b1;
          dm_we  = (iclass == CL_STORE);
          pc_we  = (iclass == CL_STORE) && mem_ack;
        end
        ST_WB: begin
          pc_we  = 1'b1;
          rf_we  = (rd != 5'd0);
          pc_sel = (iclass == CL_JAL || iclass == CL_JALR);
        end
        ST_TRAP: illegal = 1'b1;
        default: ;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{ir_q[31], ir_q[29:25]} ^ (XLEN == 64);

endmodule
